// File: rtl/sram_mem_ctrl_if.sv
// Bundles the MEM-stage request/response signals and the 16-bit SRAM pins.
// The slave modport is the controller side; the master modport is the pipeline/SRAM side.
interface sram_mem_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic               MEM_R_EN;
  logic               MEM_W_EN;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               freeze;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [15:0]        SRAM_DQ_out;
  logic               SRAM_DQ_oe;
  logic [15:0]        SRAM_DQ_in;
  logic               SRAM_WE_N;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata, SRAM_DQ_in,
    input  rdata, freeze, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata, SRAM_DQ_in,
    output rdata, freeze, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage SRAM sequencer: splits each 32-bit access into two 16-bit half-word
// accesses (low half first), freezing the pipeline until the access is finished.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int MEM_BASE    = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
  localparam int         WAW      = SRAM_AW - 1;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic               r_isWrite;
  logic [31:0]        r_wdata;
  logic [WAW-1:0]     r_word;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_sramAddr;
  logic [15:0]        r_dqOut;
  logic               r_oe;
  logic               r_weN;

  logic               w_req;
  logic               w_accept;
  logic               w_lastCnt;
  logic               w_freeze;
  logic [31:0]        w_offset;
  logic [WAW-1:0]     w_word;
  logic               w_opWrite;
  logic [31:0]        w_data;

  assign w_req     = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_accept  = (r_state == IDLE) & w_req;
  assign w_lastCnt = (r_cnt == LAST_CNT);
  assign w_offset  = bus.address - 32'(MEM_BASE);

  // On the accepting cycle the SRAM pins are loaded straight from the request,
  // so the latched copies are bypassed until they become valid.
  assign w_word    = w_accept ? WAW'(w_offset >> 2) : r_word;
  assign w_opWrite = w_accept ? bus.MEM_W_EN : r_isWrite;
  assign w_data    = w_accept ? bus.wdata : r_wdata;

  always_comb begin
    w_next   = r_state;
    w_freeze = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next   = LO;
          w_freeze = 1'b1;
        end
      end
      LO: begin
        w_freeze = 1'b1;
        if (w_lastCnt) w_next = HI;
      end
      HI: begin
        w_freeze = 1'b1;
        if (w_lastCnt) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_isWrite  <= 1'b0;
      r_wdata    <= 32'd0;
      r_word     <= '0;
      r_rdata    <= 32'd0;
      r_sramAddr <= '0;
      r_dqOut    <= 16'd0;
      r_oe       <= 1'b0;
      r_weN      <= 1'b1;
    end else begin
      r_state <= w_next;

      if (w_next != r_state)                 r_cnt <= 4'd0;
      else if (r_state == LO || r_state == HI) r_cnt <= r_cnt + 4'd1;

      if (w_accept) begin
        r_isWrite <= bus.MEM_W_EN;
        r_wdata   <= bus.wdata;
        r_word    <= w_word;
      end

      // SRAM pins are registered from the next state so they line up with LO/HI exactly.
      case (w_next)
        LO: begin
          r_sramAddr <= {w_word, 1'b0};
          if (w_opWrite) r_dqOut <= w_data[15:0];
          r_oe       <= w_opWrite;
          r_weN      <= ~w_opWrite;
        end
        HI: begin
          r_sramAddr <= {w_word, 1'b1};
          if (w_opWrite) r_dqOut <= w_data[31:16];
          r_oe       <= w_opWrite;
          r_weN      <= ~w_opWrite;
        end
        default: begin
          r_oe  <= 1'b0;
          r_weN <= 1'b1;
        end
      endcase

      if (!r_isWrite && w_lastCnt && r_state == LO) r_rdata[15:0]  <= bus.SRAM_DQ_in;
      if (!r_isWrite && w_lastCnt && r_state == HI) r_rdata[31:16] <= bus.SRAM_DQ_in;
    end
  end

  assign bus.rdata       = r_rdata;
  assign bus.freeze      = w_freeze;
  assign bus.SRAM_ADDR   = r_sramAddr;
  assign bus.SRAM_DQ_out = r_dqOut;
  assign bus.SRAM_DQ_oe  = r_oe;
  assign bus.SRAM_WE_N   = r_weN;

endmodule
